// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command controller: frame geometry, FSM
// encoding and the peripheral register map.
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int BIT_W   = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } spi_state_e;

  localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0     = 7'h00;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8    = 7'h01;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0     = 7'h02;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8    = 7'h03;
  localparam logic [ADDR_W-1:0] REG_PWM_DUTY_CYCLE = 7'h04;

  // Wire layout: R/W in bit 15, address in 14:8, data in 7:0.
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Command handshake between a requester and the SPI controller.
interface spi_controller_if;
  import spi_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_rw,
    output cmd_addr,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_rw,
    input  cmd_addr,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/spi_tick_gen.sv
// Reloading down-counter that paces every SPI phase: tick is high on the
// last clk cycle of each CLK_DIV-cycle period.
module spi_tick_gen #(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (restart || (cnt == 8'd0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tick = (cnt == 8'd0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write controller: accepts a {rw, addr, data} command and
// shifts it out MSB first as one 16-bit frame under nCs.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.slave  cmd,
  output logic             SCLK,
  output logic             COPI,
  output logic             nCs,
  output logic             busy,
  output logic             done
);

  spi_state_e          state;
  spi_state_e          state_nxt;
  logic                tick;
  logic                accept;
  logic                ready_q;
  logic [BIT_W-1:0]    bit_cnt;
  logic [BIT_W-1:0]    bit_cnt_nxt;
  logic [FRAME_W-1:0]  shreg;
  logic [FRAME_W-1:0]  shreg_nxt;
  logic                sclk_nxt;
  logic                copi_nxt;
  logic                ncs_nxt;
  logic                done_nxt;
  logic                ready_nxt;
  logic                busy_nxt;

  assign cmd.cmd_ready = ready_q;
  assign accept        = cmd.cmd_valid && ready_q;

  // The divider restarts on acceptance so SETUP is a full CLK_DIV cycles;
  // after that every phase boundary falls on its free-running reload.
  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (accept),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    sclk_nxt    = SCLK;
    copi_nxt    = COPI;
    ncs_nxt     = nCs;
    done_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = SETUP;
          shreg_nxt   = pack_frame(cmd.cmd_rw, cmd.cmd_addr, cmd.cmd_data);
          copi_nxt    = cmd.cmd_rw;
          ncs_nxt     = 1'b0;
          bit_cnt_nxt = '0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_nxt = HIGH;
          sclk_nxt  = 1'b1;
        end
      end
      HIGH: begin
        if (tick) begin
          sclk_nxt    = 1'b0;
          bit_cnt_nxt = bit_cnt + 4'd1;
          // The final fall keeps the last bit on COPI through HOLD.
          if (bit_cnt == 4'd15) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = LOW;
            shreg_nxt = {shreg[FRAME_W-2:0], 1'b0};
            copi_nxt  = shreg[FRAME_W-2];
          end
        end
      end
      LOW: begin
        if (tick) begin
          state_nxt = HIGH;
          sclk_nxt  = 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          state_nxt = GAP;
          ncs_nxt   = 1'b1;
          copi_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      GAP: begin
        if (tick) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    ready_nxt = (state_nxt == IDLE);
    busy_nxt  = (state_nxt != IDLE);
  end

  // Every pin is registered from the next-state decode above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SCLK    <= 1'b0;
      COPI    <= 1'b0;
      nCs     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      ready_q <= 1'b1;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      SCLK    <= sclk_nxt;
      COPI    <= copi_nxt;
      nCs     <= ncs_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      ready_q <= ready_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
    end
  end

endmodule
